prog_loader: RTL and testbench
==============================

# prog_loader

Byte-stream program loader sitting directly upstream of the instruction memory's write port. It accepts bytes over a valid/ready handshake, typically from a UART receiver, and packs every STEP bytes into one little-endian word. Each word is written to consecutive instruction addresses starting at 0 by driving the memory's `pgm`/`addr`/`data` port. While a load is in progress it holds the core stalled through `hold_cpu`.

## Interface
- `INSTR_ADDR_WIDTH`, default 20: word-address width; must match the instruction memory.
- `STEP`, default 4: bytes per instruction word; the word is STEP*8 bits wide.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: one-cycle pulse that begins a load; ignored unless the FSM is in IDLE or DONE.
- `word_count`  in  INSTR_ADDR_WIDTH+1: number of words to load; sampled on `start`.
- `byte_valid`  in  1: upstream byte available.
- `byte_data`  in  8: upstream byte.
- `byte_ready`  out  1: loader can accept a byte.
- `pgm`  out  1: write strobe to the instruction memory.
- `addr`  out  INSTR_ADDR_WIDTH: word write address.
- `data`  out  STEP*8: word write data.
- `hold_cpu`  out  1: high from `start` acceptance until DONE.
- `done`  out  1: load finished; level signal, cleared by the next accepted `start`.
- `error`  out  1: checksum mismatch (only with the checksum feature compiled in, otherwise tied 0).

## Operation
- States are IDLE, LOAD, WRITE, CHECK (checksum builds only) and DONE.
- IDLE/DONE on `start`:
  - latch `word_count`; clear the word index, byte counter, `done` and `error`.
  - If `word_count`==0, go straight to DONE with no writes; otherwise go to LOAD.
- LOAD:
  - `byte_ready`=1; a byte is accepted on a rising edge with `byte_valid`&&`byte_ready`.
  - Byte k (0..STEP-1) of a word goes to bits [8k+7:8k] of the shift register.
  - Accepting the STEP-th byte moves the FSM to WRITE.
- WRITE:
  - Lasts one cycle; `pgm`=1, `addr`=word index, `data`=assembled word; `byte_ready`=0.
  - Then the word index increments.
  - If index+1 == latched count: next state is CHECK (checksum builds) or DONE; otherwise LOAD.
- DONE: `done`=1, `hold_cpu`=0, `byte_ready`=0.
- Width rules:
  - `word_count` above 2**INSTR_ADDR_WIDTH saturates to 2**INSTR_ADDR_WIDTH.
  - The word index never wraps past the top address.
- `start` is ignored in LOAD, WRITE and CHECK.
- Upstream bytes presented in IDLE or DONE are not accepted (`byte_ready`=0).
- Reset, including mid-load: FSM to IDLE; `pgm`, `byte_ready`, `hold_cpu`, `done` and `error` all 0; `addr`=0; `data`=0. A partially assembled word is discarded and nothing more is written.

## Timing
- `pgm` rises the cycle after the edge that accepts the STEP-th byte and is high for exactly one cycle.
- Maximum throughput is STEP+1 cycles per word when `byte_valid` is held high.
- `hold_cpu` rises the cycle after `start` is accepted and falls on entry to DONE.
- `done` rises on entry to DONE.
- `word_count`==0: `done`=1 one cycle after `start`, and `hold_cpu` never rises.
- `addr` and `data` are registered and stable for the whole `pgm` cycle.
- All outputs are registered; none of them depends combinationally on `byte_valid`.

## Configuration
- Macro: `PROG_LOADER_CHECKSUM_EN`.
- Defined:
  - An 8-bit running sum (mod 256) of all accepted data bytes is kept and is cleared on `start`.
  - After the last WRITE the FSM enters CHECK with `byte_ready`=1 and accepts one extra byte.
  - Entering DONE: `error`=1 if that byte differs from the two's-complement of the sum (sum + byte != 0 mod 256), otherwise `error`=0.
  - `word_count`==0 skips CHECK.
- Undefined: no CHECK state, no extra byte, and `error` is constant 0.

## Test plan
- Reset release, no stimulus -> all outputs 0 and `byte_ready`=0 for 10 cycles.
- STEP=4, W=5, `word_count`=2, bytes 13 00 00 00 93 00 10 00 with `byte_valid` held high:
  - `pgm` for one cycle each with addr 0 / data 0x00000013, then addr 1 / data 0x00100093.
  - `done`=1 and `hold_cpu` falls right after the second write.
  - 10 cycles from `start` to `done` with the checksum feature off.
- `byte_valid` toggled every other cycle -> identical writes; the gaps only stretch LOAD.
- `rst` asserted after 2 bytes of word 1 -> `pgm` never rises for word 1, outputs clear immediately, and a following clean load writes correctly from addr 0.
- `word_count`=0 -> `done`=1 one cycle after `start`, no `pgm`; a second `start` pulse mid-load is ignored.
- With `PROG_LOADER_CHECKSUM_EN`, one word 01 02 03 04:
  - trailing byte 0xF6 -> `error`=0;
  - trailing byte 0x00 -> `error`=1.

Source files
------------

// File: rtl/prog_loader_if.sv
// prog_loader_if: bundles the loader's control, byte-stream and
// instruction-memory write signals.
//   start/word_count        load request and word count
//   byte_valid/byte_data    upstream byte stream, byte_ready flows back
//   pgm/addr/data           instruction-memory write port
//   hold_cpu/done/error     status
// Modports: master = the side that issues requests and bytes;
//           slave  = the loader itself.
interface prog_loader_if #(
  parameter int INSTR_ADDR_WIDTH = 20,
  parameter int STEP             = 4
);
  logic                        start;
  logic [INSTR_ADDR_WIDTH:0]   word_count;
  logic                        byte_valid;
  logic [7:0]                  byte_data;
  logic                        byte_ready;
  logic                        pgm;
  logic [INSTR_ADDR_WIDTH-1:0] addr;
  logic [STEP*8-1:0]           data;
  logic                        hold_cpu;
  logic                        done;
  logic                        error;

  modport master (
    output start, word_count, byte_valid, byte_data,
    input  byte_ready, pgm, addr, data, hold_cpu, done, error
  );

  modport slave (
    input  start, word_count, byte_valid, byte_data,
    output byte_ready, pgm, addr, data, hold_cpu, done, error
  );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: byte-stream program loader in front of the instruction
// memory write port. Packs every STEP accepted bytes (little-endian) into a
// word and writes it to consecutive word addresses from 0, holding the core
// stalled for the duration of the load.
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   bus       prog_loader_if.slave (start, word_count, byte_valid/ready,
//             byte_data, pgm, addr, data, hold_cpu, done, error)
// Optional feature: define PROG_LOADER_CHECKSUM_EN to append a trailing
// checksum byte after the last word; error reports a mismatch. Without it
// error is constant 0.
module prog_loader #(
  parameter int INSTR_ADDR_WIDTH = 20,
  parameter int STEP             = 4
) (
  input logic         clk,
  input logic         rst,
  prog_loader_if.slave bus
);

  localparam int AW  = INSTR_ADDR_WIDTH;
  localparam int WW  = STEP * 8;
  localparam int BCW = (STEP > 1) ? $clog2(STEP) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [AW:0]    MAX_WORDS = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]    ONE_W     = {{AW{1'b0}}, 1'b1};
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(STEP - 1);

  // Counts beyond the address space would never complete; clamp them.
  function automatic logic [AW:0] sat_count(input logic [AW:0] wc);
    return (wc > MAX_WORDS) ? MAX_WORDS : wc;
  endfunction

  function automatic logic [WW-1:0] put_byte(input logic [WW-1:0] w,
                                             input logic [BCW-1:0] k,
                                             input logic [7:0] b);
    logic [WW-1:0] r;
    r = w;
    for (int j = 0; j < STEP; j++) begin
      if (k == BCW'(j)) r[8*j +: 8] = b;
    end
    return r;
  endfunction

  logic [2:0]     state_q, state_d;
  logic [AW:0]    count_q, count_d;
  logic [AW-1:0]  idx_q, idx_d;
  logic [BCW-1:0] bcnt_q, bcnt_d;
  logic [WW-1:0]  shift_q, shift_d;
  logic           byte_ready_q, byte_ready_d;
  logic           pgm_q, pgm_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [WW-1:0]  data_q, data_d;
  logic           hold_q, hold_d;
  logic           done_q, done_d;
  logic           accept;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]     sum_q, sum_d;
  logic [7:0]     ck_total;
  logic           error_q, error_d;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    addr_d  = addr_q;
    data_d  = data_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    sum_d    = sum_q;
    error_d  = error_q;
    ck_total = sum_q + bus.byte_data;
`endif
    // byte_ready is registered, so it already reflects LOAD/CHECK here
    accept = bus.byte_valid && byte_ready_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          count_d = sat_count(bus.word_count);
          idx_d   = '0;
          bcnt_d  = '0;
          shift_d = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
          sum_d   = '0;
          error_d = 1'b0;
`endif
          state_d = (bus.word_count == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (accept) begin
          shift_d = put_byte(shift_q, bcnt_q, bus.byte_data);
`ifdef PROG_LOADER_CHECKSUM_EN
          sum_d   = ck_total;
`endif
          if (bcnt_q == LAST_BYTE) begin
            bcnt_d  = '0;
            state_d = S_WRITE;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
      S_WRITE: begin
        if (({1'b0, idx_q} + ONE_W) == count_q) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_LOAD;
        end
        // Hold at the top address rather than wrapping back to 0
        if (idx_q != '1) idx_d = idx_q + 1'b1;
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (accept) begin
          error_d = (ck_total != 8'd0);
          state_d = S_DONE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered copies of what the next state implies
    byte_ready_d = (state_d == S_LOAD) || (state_d == S_CHECK);
    pgm_d        = (state_d == S_WRITE);
    hold_d       = (state_d == S_LOAD) || (state_d == S_WRITE) || (state_d == S_CHECK);
    done_d       = (state_d == S_DONE);
    if ((state_q == S_LOAD) && (state_d == S_WRITE)) begin
      addr_d = idx_q;
      data_d = shift_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      idx_q        <= '0;
      bcnt_q       <= '0;
      shift_q      <= '0;
      byte_ready_q <= 1'b0;
      pgm_q        <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      hold_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q        <= '0;
      error_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      idx_q        <= idx_d;
      bcnt_q       <= bcnt_d;
      shift_q      <= shift_d;
      byte_ready_q <= byte_ready_d;
      pgm_q        <= pgm_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      hold_q       <= hold_d;
      done_q       <= done_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q        <= sum_d;
      error_q      <= error_d;
`endif
    end
  end

  assign bus.byte_ready = byte_ready_q;
  assign bus.pgm        = pgm_q;
  assign bus.addr       = addr_q;
  assign bus.data       = data_q;
  assign bus.hold_cpu   = hold_q;
  assign bus.done       = done_q;
`ifdef PROG_LOADER_CHECKSUM_EN
  assign bus.error      = error_q;
`else
  assign bus.error      = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader (INSTR_ADDR_WIDTH=5, STEP=4). Table vectors,
// hand-written reset/restart/saturation sequences and random loads checked
// against a word-packing reference model.
module tb_prog_loader;
  localparam int AW   = 5;
  localparam int STEP = 4;
  localparam int NMAX = 1 << AW;
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prog_loader_if #(.INSTR_ADDR_WIDTH(AW), .STEP(STEP)) bus();
  prog_loader #(.INSTR_ADDR_WIDTH(AW), .STEP(STEP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          wc;
    logic [63:0] bv;   // byte j at bits [8j+7:8j]
    int          gap;
    int          nwr;
    logic [31:0] d0;
    logic [31:0] d1;
    int          lat;
  } vec_t;

  int          checks   = 0;
  int          failures = 0;
  logic [7:0]  pay[$];
  logic [7:0]  tx_q[$];
  logic [AW-1:0] wr_addr[$];
  logic [31:0] wr_data[$];
  bit          hold_seen = 1'b0;
  logic        pgm_prev  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: word i is bytes i*STEP .. i*STEP+STEP-1, little-endian
  function automatic logic [31:0] model_word(input int i);
    logic [31:0] w;
    w = 32'h0;
    for (int k = 0; k < STEP; k++) w = w | (32'(pay[i*STEP + k]) << (8*k));
    return w;
  endfunction

  always @(negedge clk) begin
    if (bus.pgm) begin
      chk("pgm_width", 64'(pgm_prev), 64'd0);
      chk("ready_in_write", 64'(bus.byte_ready), 64'd0);
      wr_addr.push_back(bus.addr);
      wr_data.push_back(bus.data);
    end
    pgm_prev = bus.pgm;
    if (bus.hold_cpu) hold_seen = 1'b1;
    if (bus.done) chk("hold_at_done", 64'(bus.hold_cpu), 64'd0);
  end

  task automatic chk_idle(input string name);
    chk(name, {bus.pgm, bus.byte_ready, bus.hold_cpu, bus.done, bus.error,
               27'(bus.addr), 32'(bus.data)}, 64'd0);
  endtask

  // Issue start, feed tx_q, return edges from the start-sampling edge to done
  task automatic run_load(input string name, input int wc, input int gap,
                          input int restart_cyc, output int lat);
    int cyc;
    bit toggle;
    bit v;
    wr_addr.delete();
    wr_data.delete();
    @(negedge clk);
    hold_seen       = 1'b0;
    bus.word_count  = (AW+1)'(wc);
    bus.start       = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0; lat = -1; toggle = 1'b0;
    while (cyc < 3000) begin
      if (bus.done) begin
        lat = cyc;
        break;
      end
      toggle = ~toggle;
      case (gap)
        0:       v = 1'b1;
        1:       v = toggle;
        default: v = 1'($urandom_range(0, 1));
      endcase
      if (tx_q.size() == 0) v = 1'b0;
      bus.byte_valid = v;
      bus.byte_data  = v ? tx_q[0] : 8'($urandom);
      if (cyc == restart_cyc) begin
        bus.start      = 1'b1;
        bus.word_count = '0;
      end else begin
        bus.start = 1'b0;
      end
      if (v && bus.byte_ready) void'(tx_q.pop_front());
      @(negedge clk);
      cyc++;
    end
    bus.byte_valid = 1'b0;
    bus.start      = 1'b0;
    chk({name, "_done_bound"}, 64'(lat >= 0), 64'd1);
  endtask

  task automatic load_and_check(input string name, input int wc, input int gap,
                                input int restart_cyc, input bit bad_ck, output int lat);
    int nexp;
    logic [7:0] sum;
    logic [7:0] ckb;
    logic exp_err;
    nexp = (wc > NMAX) ? NMAX : wc;
    tx_q.delete();
    sum = 8'h0;
    for (int i = 0; i < nexp*STEP; i++) begin
      tx_q.push_back(pay[i]);
      sum = sum + pay[i];
    end
    ckb = 8'h0 - sum;
    if (bad_ck) ckb = ckb ^ 8'($urandom_range(1, 255));
    exp_err = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
    if (nexp > 0) begin
      tx_q.push_back(ckb);
      exp_err = bad_ck;
    end
`endif
    run_load(name, wc, gap, restart_cyc, lat);
    chk({name, "_nwr"}, 64'(wr_addr.size()), 64'(nexp));
    for (int i = 0; i < nexp && i < wr_addr.size(); i++) begin
      chk({name, "_addr"}, 64'(wr_addr[i]), 64'(i));
      chk({name, "_data"}, 64'(wr_data[i]), 64'(model_word(i)));
    end
    chk({name, "_done"}, 64'(bus.done), 64'd1);
    chk({name, "_hold"}, 64'(bus.hold_cpu), 64'd0);
    chk({name, "_error"}, 64'(bus.error), 64'(exp_err));
    chk({name, "_ready"}, 64'(bus.byte_ready), 64'd0);
    chk({name, "_leftover"}, 64'(tx_q.size()), 64'd0);
    if (nexp == 0) chk({name, "_hold_never"}, 64'(hold_seen), 64'd0);
  endtask

`ifdef PROG_LOADER_CHECKSUM_EN
  task automatic ck_case(input string name, input logic [7:0] trail, input logic exp_err);
    int lat;
    tx_q.delete();
    tx_q.push_back(8'h01); tx_q.push_back(8'h02);
    tx_q.push_back(8'h03); tx_q.push_back(8'h04);
    tx_q.push_back(trail);
    run_load(name, 1, 0, -1, lat);
    chk({name, "_nwr"}, 64'(wr_data.size()), 64'd1);
    chk({name, "_data"}, 64'((wr_data.size() > 0) ? wr_data[0] : 32'hx), 64'h04030201);
    chk({name, "_error"}, 64'(bus.error), 64'(exp_err));
    chk({name, "_lat"}, 64'(lat), 64'd6);
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tab[4];
    int   lat;
    int   popped;
    int   cyc;

    tab[0] = '{wc:2, bv:64'h0010009300000013, gap:0, nwr:2,
               d0:32'h00000013, d1:32'h00100093, lat:10 + CK};
    tab[1] = '{wc:2, bv:64'h0010009300000013, gap:1, nwr:2,
               d0:32'h00000013, d1:32'h00100093, lat:-1};
    tab[2] = '{wc:0, bv:64'h0, gap:0, nwr:0, d0:32'h0, d1:32'h0, lat:0};
    tab[3] = '{wc:1, bv:64'h00000000efbeadde, gap:0, nwr:1,
               d0:32'hefbeadde, d1:32'h0, lat:5 + CK};

    rst = 1'b1;
    bus.start = 1'b0; bus.word_count = '0;
    bus.byte_valid = 1'b0; bus.byte_data = 8'h0;
    repeat (3) @(negedge clk);
    chk_idle("in_reset");
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk_idle("after_reset");
    end

    for (int i = 0; i < 4; i++) begin
      pay.delete();
      for (int j = 0; j < 8; j++) pay.push_back(tab[i].bv[8*j +: 8]);
      load_and_check($sformatf("vec%0d", i), tab[i].wc, tab[i].gap, -1, 1'b0, lat);
      chk($sformatf("vec%0d_nwr_lit", i), 64'(wr_data.size()), 64'(tab[i].nwr));
      if (tab[i].nwr >= 1)
        chk($sformatf("vec%0d_d0", i), 64'((wr_data.size() >= 1) ? wr_data[0] : 32'hx), 64'(tab[i].d0));
      if (tab[i].nwr >= 2)
        chk($sformatf("vec%0d_d1", i), 64'((wr_data.size() >= 2) ? wr_data[1] : 32'hx), 64'(tab[i].d1));
      if (tab[i].lat >= 0)
        chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(tab[i].lat));
    end

    // Bytes offered while DONE must not be taken
    wr_data.delete();
    for (int i = 0; i < 4; i++) begin
      bus.byte_valid = 1'b1;
      bus.byte_data  = 8'h5a;
      @(negedge clk);
      chk("done_ready", 64'(bus.byte_ready), 64'd0);
    end
    bus.byte_valid = 1'b0;
    chk("done_no_write", 64'(wr_data.size()), 64'd0);

    // start during LOAD is ignored
    pay.delete();
    for (int j = 0; j < 8; j++) pay.push_back(8'($urandom));
    load_and_check("restart", 2, 0, 3, 1'b0, lat);

    // Reset after 2 bytes of word 1
    pay.delete();
    for (int j = 0; j < 8; j++) pay.push_back(8'($urandom));
    tx_q.delete();
    for (int j = 0; j < 8; j++) tx_q.push_back(pay[j]);
    wr_addr.delete(); wr_data.delete();
    @(negedge clk);
    bus.word_count = (AW+1)'(2);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    popped = 0; cyc = 0;
    while (popped < 6 && cyc < 100) begin
      bus.byte_valid = 1'b1;
      bus.byte_data  = tx_q[0];
      if (bus.byte_ready) begin
        void'(tx_q.pop_front());
        popped++;
      end
      @(negedge clk);
      cyc++;
    end
    chk("mid_bytes", 64'(popped), 64'd6);
    chk("mid_hold", 64'(bus.hold_cpu), 64'd1);
    rst = 1'b1;
    #1;
    chk_idle("mid_reset_now");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_idle("mid_reset_after");
    end
    bus.byte_valid = 1'b0;
    chk("mid_nwr", 64'(wr_data.size()), 64'd1);
    chk("mid_w0", 64'((wr_data.size() > 0) ? wr_data[0] : 32'hx), 64'(model_word(0)));
    load_and_check("post_rst", 2, 0, -1, 1'b0, lat);
    chk("post_rst_lat", 64'(lat), 64'(10 + CK));

    // word_count above 2**AW clamps to the full address space
    pay.delete();
    for (int j = 0; j < NMAX*STEP; j++) pay.push_back(8'($urandom));
    load_and_check("sat", 40, 0, -1, 1'b0, lat);
    chk("sat_lat", 64'(lat), 64'(NMAX*(STEP+1) + CK));

`ifdef PROG_LOADER_CHECKSUM_EN
    ck_case("ck_good", 8'hf6, 1'b0);
    ck_case("ck_bad", 8'h00, 1'b1);
`endif

    for (int r = 0; r < 8; r++) begin
      int wc;
      wc = int'($urandom_range(1, 6));
      pay.delete();
      for (int j = 0; j < wc*STEP; j++) pay.push_back(8'($urandom));
      load_and_check($sformatf("rnd%0d", r), wc, 2, -1, 1'($urandom_range(0, 1)), lat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
